pwm_dac: RTL and testbench
==========================

PWM_DAC -- requirements
Module: pwm_dac

Interface
REQ-001 Parameter CODE_WIDTH, default 10: sample code width. The PWM period is 2^CODE_WIDTH clk cycles.
REQ-002 Parameter FIFO_DEPTH, default 4: sample buffer entries; must be a power of 2 and at least 2.
REQ-003 clk  input  1: PWM clock domain clock; all logic is on its rising edge.
REQ-004 rst_n  input  1: reset; asynchronous assert, active-low.
REQ-005 code_in  input  CODE_WIDTH: sample duty code (unsigned).
REQ-006 code_valid  input  1: code_in is valid this cycle.
REQ-007 code_ready  output  1: buffer can accept a sample; a push occurs when valid and ready are both high.
REQ-008 pwm_out  output  1: registered PWM bit, intended for the top-level PWM IOB register.
REQ-009 sample_tick  output  1: one-cycle pulse when a new sample takes effect.
REQ-010 underrun  output  1: one-cycle pulse when a period boundary finds the buffer empty.
REQ-011 underrun_count  output  16: saturating underrun tally; present only with PWM_DAC_UNDERRUN_CNT_EN.

Function
REQ-012 Period counter cnt (CODE_WIDTH bits) shall free-run from 0 to 2^CODE_WIDTH-1 and wrap to 0.
REQ-013 Push and pop shall be in FIFO order; one push and one pop may occur in the same cycle.
REQ-014 code_ready shall equal "buffer not full", taken from registered state only.
- When full, a push is refused even if a pop occurs in the same cycle.
- There is no valid-to-ready combinational path.
REQ-015 Load: in the cycle where cnt==2^CODE_WIDTH-1 and the buffer is non-empty, the head shall be popped into active_code at the same edge cnt wraps to 0.
REQ-016 Underrun: at that boundary with the buffer empty, active_code shall hold its previous value.
- A push in that same cycle is stored and does not bypass; it is not loaded until the next boundary.
REQ-017 pwm_out shall be registered from (cnt < active_code); output therefore lags cnt by exactly one cycle.
- The result is active_code high cycles per 2^CODE_WIDTH-cycle period.
- Code 0 gives constant low.
- Code 2^CODE_WIDTH-1 gives one low cycle per period.
REQ-018 sample_tick shall be high for exactly the one cycle in which cnt==0 following a successful load; otherwise low.
REQ-019 underrun shall be high for exactly the one cycle in which cnt==0 following an empty-buffer boundary; sample_tick and underrun are never both high.
REQ-020 Widths: the cnt/active_code comparison is unsigned CODE_WIDTH-bit; buffer pointers are log2(FIFO_DEPTH)+1 bits, with the MSB distinguishing full from empty.

Reset
REQ-021 While rst_n is low, the block shall be held in this state:
- cnt=0, active_code=0, pwm_out=0, sample_tick=0, underrun=0, underrun_count=0.
- Buffer empty, code_ready=1.
REQ-022 Assertion mid-period shall discard all buffered samples immediately. After release, cnt restarts from 0 with a full-length period.

Configuration
REQ-023 Macro PWM_DAC_UNDERRUN_CNT_EN, when defined:
- Adds the underrun_count port and a 16-bit counter.
- The counter increments on each underrun pulse and saturates at 16'hFFFF.
REQ-024 When the macro is undefined, the port and counter shall be absent and all other behaviour shall be identical.

Structure
REQ-025 Shared package dac_pkg shall hold:
- the default CODE_WIDTH and FIFO_DEPTH constants;
- the UNDERRUN_CNT_WIDTH=16 constant;
- a code_t typedef.
REQ-026 The buffer shall be a sub-module named sample_fifo: synchronous FIFO with push/pop/full/empty and registered flags. Counter, load logic and comparator live in pwm_dac.

Verification (CODE_WIDTH=4, FIFO_DEPTH=4, period 16)
REQ-027 Reset with rst_n low for 3 cycles:
- During reset: pwm_out=0, code_ready=1, sample_tick=0.
- After release: an empty buffer at the first boundary gives underrun at cycle 16 and pwm_out stays 0.
REQ-028 Push code 4 during period 0:
- sample_tick pulses at the next cnt==0.
- pwm_out is high exactly 4 of every 16 cycles, starting one cycle after cnt==0.
REQ-029 Push codes 0 then 15 in successive periods: pwm_out is 0 for 16 cycles, then high 15 and low 1.
REQ-030 Push 5 codes back-to-back with code_valid held:
- 4 are accepted and code_ready drops after the 4th.
- The 5th is accepted only after the next boundary pop.
- Loaded codes come out in push order, one per period.
REQ-031 Starve the buffer after code 8:
- underrun pulses at each boundary and the duty stays 8/16.
- With the macro defined, underrun_count counts 1, 2, 3...
- With the count forced near the limit, it sticks at 16'hFFFF.
REQ-032 Assert rst_n at cnt=7 with 3 samples buffered:
- Outputs clear immediately.
- After release, the buffer is empty, cnt restarts at 0, and the next boundary gives underrun.

Source files
------------

// File: rtl/dac_pkg.sv
// Shared constants and types for the PWM DAC and its sample buffer.
package dac_pkg;

    localparam int unsigned CODE_WIDTH_DEF     = 10;
    localparam int unsigned FIFO_DEPTH_DEF     = 4;
    localparam int unsigned UNDERRUN_CNT_WIDTH = 16;

    typedef logic [CODE_WIDTH_DEF-1:0] code_t;

endpackage : dac_pkg

// File: rtl/pwm_dac_sample_fifo.sv
// sample_fifo: synchronous FIFO with extra-MSB pointers and registered full/empty flags.
module sample_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             push_ok;
    logic             pop_ok;

    // Flags are computed from next pointers so they are valid straight out of the register.
    always_comb begin
        push_ok  = push_i && !full_q;
        pop_ok   = pop_i && !empty_q;
        wr_ptr_d = wr_ptr_q + PW'(push_ok);
        rd_ptr_d = rd_ptr_q + PW'(pop_ok);
        empty_d  = (wr_ptr_d == rd_ptr_d);
        full_d   = (wr_ptr_d == (rd_ptr_d ^ {1'b1, {AW{1'b0}}}));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule : sample_fifo

// File: rtl/pwm_dac.sv
// pwm_dac: buffered PWM DAC, one sample per 2^CODE_WIDTH-cycle period.
// Optional saturating underrun tally enabled by PWM_DAC_UNDERRUN_CNT_EN.
module pwm_dac
    import dac_pkg::*;
#(
    parameter int unsigned CODE_WIDTH = CODE_WIDTH_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [CODE_WIDTH-1:0]         code_in,
    input  logic                          code_valid,
    output logic                          code_ready,
    output logic                          pwm_out,
    output logic                          sample_tick,
    output logic                          underrun
`ifdef PWM_DAC_UNDERRUN_CNT_EN
    ,
    output logic [UNDERRUN_CNT_WIDTH-1:0] underrun_count
`endif
);

    localparam logic [CODE_WIDTH-1:0] CNT_MAX = '1;

    logic [CODE_WIDTH-1:0] cnt_q, cnt_d;
    logic [CODE_WIDTH-1:0] active_code_q, active_code_d;
    logic                  pwm_q, pwm_d;
    logic                  tick_q, tick_d;
    logic                  underrun_q, underrun_d;
    logic [CODE_WIDTH-1:0] fifo_data;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  boundary;
    logic                  load;

    sample_fifo #(
        .WIDTH (CODE_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (code_valid),
        .data_i  (code_in),
        .pop_i   (boundary),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Boundary is the last count of a period; the load lands as cnt wraps to 0.
    always_comb begin
        boundary      = (cnt_q == CNT_MAX);
        load          = boundary && !fifo_empty;
        cnt_d         = cnt_q + CODE_WIDTH'(1);
        active_code_d = load ? fifo_data : active_code_q;
        pwm_d         = (cnt_q < active_code_q);
        tick_d        = load;
        underrun_d    = boundary && fifo_empty;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            active_code_q <= '0;
            pwm_q         <= 1'b0;
            tick_q        <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            active_code_q <= active_code_d;
            pwm_q         <= pwm_d;
            tick_q        <= tick_d;
            underrun_q    <= underrun_d;
        end
    end

`ifdef PWM_DAC_UNDERRUN_CNT_EN
    logic [UNDERRUN_CNT_WIDTH-1:0] ucnt_q, ucnt_d;

    always_comb begin
        ucnt_d = ucnt_q;
        if (underrun_q && (ucnt_q != '1)) begin
            ucnt_d = ucnt_q + UNDERRUN_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ucnt_q <= '0;
        end else begin
            ucnt_q <= ucnt_d;
        end
    end

    assign underrun_count = ucnt_q;
`endif

    assign code_ready  = !fifo_full;
    assign pwm_out     = pwm_q;
    assign sample_tick = tick_q;
    assign underrun    = underrun_q;

endmodule : pwm_dac

// File: tb/tb_pwm_dac.sv
// Randomised scoreboard bench for pwm_dac (CODE_WIDTH=4, FIFO_DEPTH=4, period 16).
module tb_pwm_dac;

    localparam int unsigned CW     = 4;
    localparam int unsigned DEPTH  = 4;
    localparam int          PERIOD = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CW-1:0] code_in = '0;
    logic          code_valid = 1'b0;
    logic          code_ready;
    logic          pwm_out;
    logic          sample_tick;
    logic          underrun;
`ifdef PWM_DAC_UNDERRUN_CNT_EN
    logic [15:0]   underrun_count;
    int            ucnt_exp = 0;
`endif

    pwm_dac #(
        .CODE_WIDTH (CW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .code_in        (code_in),
        .code_valid     (code_valid),
        .code_ready     (code_ready),
        .pwm_out        (pwm_out),
        .sample_tick    (sample_tick),
        .underrun       (underrun)
`ifdef PWM_DAC_UNDERRUN_CNT_EN
        ,
        .underrun_count (underrun_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_tick;
        int code;
    } ev_t;

    int  n_tests = 0;
    int  n_fail  = 0;
    ev_t exp_q[$];
    int  model_buf[$];
    int  cnt_m     = 0;
    int  active_m  = 0;
    int  mon_active = 0;
    bit  can_push;
    ev_t ev;
    logic exp_pwm;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: the buffer is a queue, each period end either loads the head or underruns.
    always @(posedge clk) begin
        if (!rst_n) begin
            model_buf.delete();
            exp_q.delete();
            cnt_m    = 0;
            active_m = 0;
        end else begin
            can_push = (model_buf.size() < DEPTH);
            if (cnt_m == PERIOD - 1) begin
                if (model_buf.size() > 0) begin
                    active_m = model_buf.pop_front();
                    exp_q.push_back('{1'b1, active_m});
                end else begin
                    exp_q.push_back('{1'b0, active_m});
                end
            end
            if (code_valid && can_push) model_buf.push_back(int'(code_in));
            cnt_m = (cnt_m + 1) % PERIOD;
        end
    end

    // Monitor: per-cycle duty/ready checks, and pops an expected event whenever the DUT signals one.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_pwm_out", pwm_out, 0);
            check("rst_sample_tick", sample_tick, 0);
            check("rst_underrun", underrun, 0);
            check("rst_code_ready", code_ready, 1);
            mon_active = 0;
`ifdef PWM_DAC_UNDERRUN_CNT_EN
            check("rst_underrun_count", underrun_count, 0);
            ucnt_exp = 0;
`endif
        end else begin
            exp_pwm = (((cnt_m + PERIOD - 1) % PERIOD) < mon_active);
            check("pwm_out", pwm_out, exp_pwm);
            check("code_ready", code_ready, (model_buf.size() < DEPTH) ? 1 : 0);
`ifdef PWM_DAC_UNDERRUN_CNT_EN
            check("underrun_count", underrun_count, ucnt_exp);
`endif
            if (sample_tick || underrun || (cnt_m == 0 && exp_q.size() > 0)) begin
                if (exp_q.size() == 0) begin
                    check("spurious_event", {30'd0, sample_tick, underrun}, 0);
                end else begin
                    ev = exp_q.pop_front();
                    check("sample_tick", sample_tick, ev.is_tick);
                    check("underrun", underrun, !ev.is_tick);
                    check("event_phase", cnt_m, 0);
                    mon_active = ev.code;
`ifdef PWM_DAC_UNDERRUN_CNT_EN
                    if (!ev.is_tick && ucnt_exp < 16'hFFFF) ucnt_exp++;
`endif
                end
            end
        end
    end

    task automatic idle(input int n);
        code_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int c);
        int budget = 0;
        code_in    = CW'(c);
        code_valid = 1'b1;
        @(negedge clk);
        while (!code_ready && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (!code_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL push_timeout: code_ready stuck at 0 for code %0d", c);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cnt(input int k);
        int budget = 0;
        code_valid = 1'b0;
        @(negedge clk);
        while (cnt_m != k && budget < 64) begin
            @(negedge clk);
            budget++;
        end
        if (cnt_m != k) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_cnt: phase %0d never reached, at %0d", k, cnt_m);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(20);

        push(4);
        idle(2 * PERIOD);

        wait_cnt(2);
        push(0);
        wait_cnt(2);
        push(15);
        idle(3 * PERIOD);

        wait_cnt(1);
        for (int i = 0; i < 5; i++) push(int'($urandom_range(1, 15)));
        idle(6 * PERIOD + 4);

        push(8);
        idle(4 * PERIOD + 8);
`ifdef PWM_DAC_UNDERRUN_CNT_EN
        wait_cnt(5);
        force dut.ucnt_q = 16'hFFFE;
        ucnt_exp = 16'hFFFE;
        @(posedge clk);
        #1 release dut.ucnt_q;
        idle(3 * PERIOD);
`endif

        for (int i = 0; i < 40; i++) begin
            idle(int'($urandom_range(0, 20)));
            push(int'($urandom_range(0, 15)));
        end
        idle(6 * PERIOD);

        wait_cnt(1);
        for (int i = 0; i < 3; i++) push(int'($urandom_range(1, 15)));
        wait_cnt(7);
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2 * PERIOD + 4);

        check("final_queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_pwm_dac
